product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_if.sv | 38 +++
 rtl/product_accumulator.sv | 114 +++++++++++
 tb/tb_product_accumulator.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Handshake bundle between a producer of signed products and the
// product accumulator.
//
// Ports (signals carried by the interface):
//   start, len       : begin a new accumulation of len products
//   in_valid/in_ready: product beat handshake, in_prod is the signed product
//   out_valid/out_ready: result handshake, out_acc is the signed sum and
//                      out_ovf the sticky signed-overflow flag
//   busy             : accumulator is not idle
// Modports:
//   master : the driver side (producer and result consumer)
//   slave  : the accumulator side
interface product_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;
  logic              busy;

  modport master (
    output start, len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of signed products into a wider signed
// sum, flagging signed overflow, and presents the result through a
// valid/ready handshake.
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : product_accumulator_if slave modport
//         start/len in, in_valid/in_ready/in_prod beat handshake,
//         out_valid/out_ready/out_acc/out_ovf result handshake, busy out
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ovf_r;

  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic             add_ovf_s;

  // Two's-complement overflow: equal operand signs, differing result sign.
  function automatic logic add_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Sign-extend the product and form the wrapping sum plus its overflow flag.
  always_comb begin
    prod_ext_s = ACC_W'($signed(bus.in_prod));
    sum_s      = acc_r + prod_ext_s;
    add_ovf_s  = add_overflow(acc_r[ACC_W-1], prod_ext_s[ACC_W-1],
                              sum_s[ACC_W-1]);
  end

  // Control FSM together with the accumulator, beat counter and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
            cnt_r <= bus.len;
            // A zero-length request completes immediately with a zero sum.
            if (bus.len == {CNT_W{1'b0}}) begin
              state_r <= DONE;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc_r <= sum_s;
            if (add_ovf_s) begin
              ovf_r <= 1'b1;
            end else begin
              ovf_r <= ovf_r;
            end
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              state_r <= DONE;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode the state register only; data outputs are registers.
  assign bus.in_ready  = (state_r == ACCUM);
  assign bus.out_valid = (state_r == DONE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.out_acc   = acc_r;
  assign bus.out_ovf   = ovf_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed testbench for product_accumulator: a 72-bit accumulator instance
// carries most scenarios, a 64-bit instance exercises wrap and overflow.
module tb_product_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  product_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) ifa ();
  product_accumulator_if #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) ifb ();

  product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", ifa.in_ready); end
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", ifa.out_valid); end
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", ifa.busy); end
    checks++; if (ifa.out_acc !== 72'd0) begin failures++; $display("FAIL reset_out_acc got=%0h exp=0", ifa.out_acc); end
    checks++; if (ifa.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%0b exp=0", ifa.out_ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_sum();
    ifa.out_ready = 1'b1;
    ifa.start = 1'b1; ifa.len = 8'd3;
    tick();
    ifa.start = 1'b0; ifa.len = 8'd0;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%0b exp=1", ifa.in_ready); end
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", ifa.busy); end
    ifa.in_valid = 1'b1; ifa.in_prod = 64'd5;
    tick();
    ifa.in_prod = -64'sd7;
    tick();
    ifa.in_prod = 64'd100;
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", ifa.out_valid); end
    tick();
    ifa.in_valid = 1'b0; ifa.in_prod = 64'd0;
    checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0b exp=1", ifa.out_valid); end
    checks++; if (ifa.out_acc !== 72'd98) begin failures++; $display("FAIL basic_out_acc got=%0h exp=62", ifa.out_acc); end
    checks++; if (ifa.out_ovf !== 1'b0) begin failures++; $display("FAIL basic_out_ovf got=%0b exp=0", ifa.out_ovf); end
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL basic_done_in_ready got=%0b exp=0", ifa.in_ready); end
    tick();
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%0b exp=0", ifa.busy); end
    checks++; if (ifa.out_acc !== 72'd98) begin failures++; $display("FAIL basic_idle_hold got=%0h exp=62", ifa.out_acc); end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_len_zero();
    ifa.out_ready = 1'b0;
    ifa.start = 1'b1; ifa.len = 8'd0;
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL len0_in_ready_idle got=%0b exp=0", ifa.in_ready); end
    tick();
    ifa.start = 1'b0;
    checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL len0_out_valid got=%0b exp=1", ifa.out_valid); end
    checks++; if (ifa.out_acc !== 72'd0) begin failures++; $display("FAIL len0_out_acc got=%0h exp=0", ifa.out_acc); end
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL len0_in_ready_done got=%0b exp=0", ifa.in_ready); end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL len0_release got=%0b exp=0", ifa.out_valid); end
  endtask

  task automatic test_overflow();
    ifa.start = 1'b1; ifa.len = 8'd4;
    ifb.start = 1'b1; ifb.len = 8'd4;
    tick();
    ifa.start = 1'b0; ifb.start = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_prod = 64'h8000_0000_0000_0000;
    ifb.in_valid = 1'b1; ifb.in_prod = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 4; i++) tick();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    checks++; if (ifa.out_acc !== 72'hFE_0000_0000_0000_0000) begin failures++; $display("FAIL ovf72_out_acc got=%0h exp=fe0000000000000000", ifa.out_acc); end
    checks++; if (ifa.out_ovf !== 1'b0) begin failures++; $display("FAIL ovf72_out_ovf got=%0b exp=0", ifa.out_ovf); end
    checks++; if (ifb.out_valid !== 1'b1) begin failures++; $display("FAIL ovf64_out_valid got=%0b exp=1", ifb.out_valid); end
    checks++; if (ifb.out_acc !== 64'd0) begin failures++; $display("FAIL ovf64_out_acc got=%0h exp=0", ifb.out_acc); end
    checks++; if (ifb.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf64_out_ovf got=%0b exp=1", ifb.out_ovf); end
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    checks++; if (ifb.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf64_sticky_idle got=%0b exp=1", ifb.out_ovf); end
    // A new start clears the sticky flag.
    ifb.start = 1'b1; ifb.len = 8'd0;
    tick();
    ifb.start = 1'b0;
    checks++; if (ifb.out_ovf !== 1'b0) begin failures++; $display("FAIL ovf64_clear got=%0b exp=0", ifb.out_ovf); end
    ifb.out_ready = 1'b1;
    tick();
    ifb.out_ready = 1'b0;
  endtask

  task automatic test_bubbles();
    ifa.out_ready = 1'b0;
    ifa.start = 1'b1; ifa.len = 8'd2;
    tick();
    ifa.start = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_prod = 64'd1000;
    tick();
    ifa.in_valid = 1'b0; ifa.in_prod = 64'd12345;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready cyc=%0d got=%0b exp=1", i, ifa.in_ready); end
      checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL bubble_out_valid cyc=%0d got=%0b exp=0", i, ifa.out_valid); end
      tick();
    end
    ifa.in_valid = 1'b1; ifa.in_prod = -64'sd1;
    tick();
    ifa.in_valid = 1'b0; ifa.in_prod = 64'd777;
    for (int i = 0; i < 5; i++) begin
      checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid cyc=%0d got=%0b exp=1", i, ifa.out_valid); end
      checks++; if (ifa.out_acc !== 72'd999) begin failures++; $display("FAIL stall_out_acc cyc=%0d got=%0h exp=3e7", i, ifa.out_acc); end
      checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", i, ifa.in_ready); end
      tick();
    end
    ifa.out_ready = 1'b1;
    tick();
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL stall_handshake got=%0b exp=0", ifa.out_valid); end
    tick();
    checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL stall_single got=%0b exp=0", ifa.out_valid); end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    ifa.start = 1'b1; ifa.len = 8'd3;
    tick();
    ifa.start = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_prod = 64'd50;
    tick();
    // Reset wins over start, in_valid and out_ready in the same cycle.
    rst = 1'b1; ifa.start = 1'b1; ifa.len = 8'd2; ifa.out_ready = 1'b1;
    tick();
    rst = 1'b0; ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", ifa.busy); end
    checks++; if (ifa.out_acc !== 72'd0) begin failures++; $display("FAIL abort_out_acc got=%0h exp=0", ifa.out_acc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ifa.out_valid !== 1'b0) begin failures++; $display("FAIL abort_no_valid cyc=%0d got=%0b exp=0", i, ifa.out_valid); end
      tick();
    end
    ifa.start = 1'b1; ifa.len = 8'd1;
    tick();
    ifa.start = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_prod = 64'd9;
    tick();
    ifa.in_valid = 1'b0;
    checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL abort_new_valid got=%0b exp=1", ifa.out_valid); end
    checks++; if (ifa.out_acc !== 72'd9) begin failures++; $display("FAIL abort_new_acc got=%0h exp=9", ifa.out_acc); end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    ifa.out_ready = 1'b0;
    ifa.start = 1'b1; ifa.len = 8'd2;
    tick();
    ifa.len = 8'd7;
    ifa.in_valid = 1'b1; ifa.in_prod = 64'd3;
    tick();
    ifa.in_prod = 64'd4;
    tick();
    ifa.in_valid = 1'b0;
    checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL ign_count got=%0b exp=1", ifa.out_valid); end
    checks++; if (ifa.out_acc !== 72'd7) begin failures++; $display("FAIL ign_out_acc got=%0h exp=7", ifa.out_acc); end
    tick();
    tick();
    checks++; if (ifa.out_valid !== 1'b1) begin failures++; $display("FAIL ign_done_valid got=%0b exp=1", ifa.out_valid); end
    checks++; if (ifa.out_acc !== 72'd7) begin failures++; $display("FAIL ign_done_acc got=%0h exp=7", ifa.out_acc); end
    ifa.start = 1'b0; ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL ign_release got=%0b exp=0", ifa.busy); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.len = 8'd0; ifa.in_valid = 1'b0; ifa.in_prod = 64'd0; ifa.out_ready = 1'b0;
    ifb.start = 1'b0; ifb.len = 8'd0; ifb.in_valid = 1'b0; ifb.in_prod = 64'd0; ifb.out_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_len_zero();
    test_overflow();
    test_bubbles();
    test_reset_abort();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
